game_countdown_timer: RTL and testbench

Consumer end of the slow-clock tick interface: receives the one-cycle `tick` pulse produced by the design's one-second counter and runs a loadable MM:SS BCD countdown for the game round. It drives the score/timer display digits, flags round expiry with a one-cycle `time_up` pulse, and raises a low-time warning. It sits in the Control hierarchy between the slow-clock generator and the game state machine.

---
 rtl/game_timer_pkg.sv | 24 ++
 rtl/bcd_down_digit.sv | 32 +++
 rtl/game_countdown_timer.sv | 132 +++++++++++++
 tb/tb_game_countdown_timer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types, constants and BCD helpers for the MM:SS game countdown timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_ONES = 4'd9;
    localparam bcd_t BCD_MAX_TENS = 4'd5;

    function automatic bcd_t clamp_bcd(input bcd_t v, input bcd_t max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic [9:0] total_secs(input bcd_t m, input bcd_t t, input bcd_t o);
        return 10'(m) * 10'd60 + 10'(t) * 10'd10 + 10'(o);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One loadable BCD down-counting digit; wraps 0 -> MAX and raises borrow_o on that wrap.
module bcd_down_digit
    import game_timer_pkg::*;
#(
    parameter int MAX     = 9,
    parameter int RST_VAL = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic dec_en_i,
    output bcd_t digit_o,
    output logic borrow_o
);

    bcd_t digit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'(RST_VAL);
        end else if (load_i) begin
            digit_q <= clamp_bcd(load_val_i, 4'(MAX));
        end else if (dec_en_i) begin
            digit_q <= (digit_q == 4'd0) ? 4'(MAX) : digit_q - 4'd1;
        end
    end

    assign digit_o  = digit_q;
    assign borrow_o = dec_en_i && (digit_q == 4'd0);

endmodule

// File: rtl/game_countdown_timer.sv
// Loadable MM:SS BCD round timer driven by a one-cycle tick; warn blinks when GAME_TIMER_BLINK_EN is defined.
// State | meaning: IDLE loaded/waiting, RUN counting, PAUSED frozen, EXPIRED holding 00:00.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int INIT_MIN  = 2,
    parameter int INIT_SEC  = 0,
    parameter int WARN_SECS = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [7:0] load_sec,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       time_up,
    output logic       warn
);

    // Reset asserts asynchronously, deasserts two clk edges after resetN rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    timer_state_t state_q, state_d;
    logic         dec, time_up_d, win_d;
    logic         borrow_ones, borrow_tens, borrow_min;
    logic [9:0]   total_now, total_d;
    logic         running_q, expired_q, time_up_q, warn_q;

    bcd_down_digit #(.MAX(9), .RST_VAL(INIT_SEC % 10)) u_ones (
        .clk(clk), .rst_n(rst_n), .load_i(load), .load_val_i(load_sec[3:0]),
        .dec_en_i(dec), .digit_o(sec_ones), .borrow_o(borrow_ones)
    );
    bcd_down_digit #(.MAX(5), .RST_VAL(INIT_SEC / 10)) u_tens (
        .clk(clk), .rst_n(rst_n), .load_i(load), .load_val_i(load_sec[7:4]),
        .dec_en_i(borrow_ones), .digit_o(sec_tens), .borrow_o(borrow_tens)
    );
    bcd_down_digit #(.MAX(9), .RST_VAL(INIT_MIN)) u_min (
        .clk(clk), .rst_n(rst_n), .load_i(load), .load_val_i(load_min),
        .dec_en_i(borrow_tens), .digit_o(min_digit), .borrow_o(borrow_min)
    );

    assign total_now = total_secs(min_digit, sec_tens, sec_ones);

    always_comb begin
        state_d   = state_q;
        time_up_d = 1'b0;
        dec       = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d   = (total_now == 10'd0) ? ST_EXPIRED : ST_RUN;
                    time_up_d = (total_now == 10'd0);
                end
                ST_RUN: if (pause) begin
                    state_d = ST_PAUSED;
                end else if (tick && !start) begin
                    dec = 1'b1;
                    if (total_now == 10'd1) begin
                        state_d   = ST_EXPIRED;
                        time_up_d = 1'b1;
                    end
                end
                ST_PAUSED: if (start) state_d = ST_RUN;
                default: ;
            endcase
        end

        if (load)
            total_d = total_secs(clamp_bcd(load_min, BCD_MAX_ONES),
                                 clamp_bcd(load_sec[7:4], BCD_MAX_TENS),
                                 clamp_bcd(load_sec[3:0], BCD_MAX_ONES));
        else if (dec)
            total_d = total_now - 10'd1;
        else
            total_d = total_now;

        win_d = ((state_d == ST_RUN) || (state_d == ST_PAUSED)) &&
                (total_d != 10'd0) && (32'(total_d) <= WARN_SECS);
    end

`ifdef GAME_TIMER_BLINK_EN
    logic win_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            time_up_q <= 1'b0;
            warn_q    <= 1'b0;
`ifdef GAME_TIMER_BLINK_EN
            win_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
            time_up_q <= time_up_d;
`ifdef GAME_TIMER_BLINK_EN
            win_q <= win_d;
            if (!win_d)     warn_q <= 1'b0;
            else if (!win_q) warn_q <= 1'b1;
            else if (dec)    warn_q <= ~warn_q;
`else
            warn_q <= win_d;
`endif
        end
    end

    assign running = running_q;
    assign expired = expired_q;
    assign time_up = time_up_q;
    assign warn    = warn_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Randomized bench for game_countdown_timer against a seconds-based reference model.
module tb_game_countdown_timer;

    localparam int WARN = 10;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, load = 1'b0;
    logic [3:0] load_min = 4'd0;
    logic [7:0] load_sec = 8'd0;
    logic [3:0] min_digit, sec_tens, sec_ones;
    logic       running, expired, time_up, warn;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining seconds and a symbolic mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_rem, m_mode;
    bit m_tu, m_warn, m_win;

    game_countdown_timer #(.INIT_MIN(2), .INIT_SEC(0), .WARN_SECS(WARN)) dut (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .min_digit(min_digit), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .expired(expired), .time_up(time_up), .warn(warn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_rem = 120; m_mode = M_IDLE; m_tu = 0; m_warn = 0; m_win = 0;
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(input bit ld, input bit ps, input bit st, input bit tk,
                              input int lm, input int ls);
        bit counted, win_new;
        counted = 0;
        m_tu = 0;
        if (ld) begin
            m_rem  = clampv(lm, 9) * 60 + clampv(ls / 16, 5) * 10 + clampv(ls % 16, 9);
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE && st) begin
            if (m_rem == 0) begin m_mode = M_EXP; m_tu = 1; end
            else m_mode = M_RUN;
        end else if (m_mode == M_RUN && ps) begin
            m_mode = M_PAUSE;
        end else if (m_mode == M_RUN && !st && tk) begin
            counted = 1;
            m_rem--;
            if (m_rem == 0) begin m_mode = M_EXP; m_tu = 1; end
        end else if (m_mode == M_PAUSE && st) begin
            m_mode = M_RUN;
        end
        win_new = (m_mode == M_RUN || m_mode == M_PAUSE) && m_rem >= 1 && m_rem <= WARN;
`ifdef GAME_TIMER_BLINK_EN
        if (!win_new)    m_warn = 0;
        else if (!m_win) m_warn = 1;
        else if (counted) m_warn = ~m_warn;
`else
        m_warn = win_new;
`endif
        m_win = win_new;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".min"},  min_digit, m_rem / 60);
        chk({tag, ".tens"}, sec_tens,  (m_rem % 60) / 10);
        chk({tag, ".ones"}, sec_ones,  m_rem % 10);
        chk({tag, ".run"},  running,   int'(m_mode == M_RUN));
        chk({tag, ".exp"},  expired,   int'(m_mode == M_EXP));
        chk({tag, ".tup"},  time_up,   int'(m_tu));
        chk({tag, ".warn"}, warn,      int'(m_warn));
    endtask

    task automatic cyc(input string tag, input bit ld, input bit ps, input bit st, input bit tk,
                       input logic [3:0] lm, input logic [7:0] ls);
        load = ld; pause = ps; start = st; tick = tk; load_min = lm; load_sec = ls;
        @(posedge clk);
        model_step(ld, ps, st, tk, int'(lm), int'(ls));
        @(negedge clk);
        check_all(tag);
        load = 0; pause = 0; start = 0; tick = 0;
    endtask

    task automatic do_load(input logic [3:0] lm, input logic [7:0] ls);
        cyc("load", 1, 0, 0, 0, lm, ls);
    endtask
    task automatic do_start();  cyc("start", 0, 0, 1, 0, 4'd0, 8'd0); endtask
    task automatic do_tick();   cyc("tick",  0, 0, 0, 1, 4'd0, 8'd0); endtask

    task automatic release_reset();
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) cyc("rstrel", 0, 0, 0, 0, 4'd0, 8'd0);
    endtask

    initial begin
        model_reset();
        #23;
        check_all("reset");
        release_reset();
        chk("rst_min", min_digit, 2);
        chk("rst_sec", {sec_tens, sec_ones}, 0);

        do_start();
        for (int i = 0; i < 3; i++) do_tick();
        chk("t157", {min_digit, sec_tens, sec_ones}, 12'h157);
        chk("t157_run", running, 1);

        do_load(4'd0, 8'h10);
        do_start();
        for (int i = 0; i < 10; i++) do_tick();
        chk("exp_tup", time_up, 1);
        chk("exp_flag", expired, 1);
        chk("exp_zero", {min_digit, sec_tens, sec_ones}, 0);
        do_tick();
        chk("exp_tup_once", time_up, 0);
        cyc("exp_st_tk", 0, 0, 1, 1, 4'd0, 8'd0);
        cyc("exp_ps", 0, 1, 0, 1, 4'd0, 8'd0);
        chk("exp_hold", expired, 1);

        do_load(4'd1, 8'h00);
        do_start();
        do_tick();
        chk("borrow", {min_digit, sec_tens, sec_ones}, 12'h059);

        do_load(4'd0, 8'h30);
        do_start();
        cyc("pause_tick", 0, 1, 0, 1, 4'd0, 8'd0);
        chk("pause_hold", {min_digit, sec_tens, sec_ones}, 12'h030);
        chk("pause_run", running, 0);
        cyc("resume_tick", 0, 0, 1, 1, 4'd0, 8'd0);
        chk("resume_hold", {min_digit, sec_tens, sec_ones}, 12'h030);
        do_tick();
        chk("resume_cnt", {min_digit, sec_tens, sec_ones}, 12'h029);

        do_load(4'd0, 8'h12);
        do_start();
        do_tick();
        chk("warn_011", warn, 0);
        do_tick();
        chk("warn_010", warn, 1);
        for (int i = 0; i < 10; i++) do_tick();
        chk("warn_zero", warn, 0);

        do_load(4'd0, 8'h45);
        do_start();
        @(negedge clk);
        #2 resetN = 1'b0;
        model_reset();
        #1 check_all("midrst");
        chk("midrst_min", min_digit, 2);
        release_reset();
        do_load(4'hF, 8'h7A);
        chk("clamp", {min_digit, sec_tens, sec_ones}, 12'h959);

        for (int i = 0; i < 4000; i++) begin
            bit ld, ps, st, tk;
            logic [3:0] lm;
            logic [7:0] ls;
            ld = ($urandom_range(0, 99) < 3);
            ps = ($urandom_range(0, 99) < 5);
            st = ($urandom_range(0, 99) < 8);
            tk = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 3) == 0) begin
                lm = 4'($urandom_range(0, 15));
                ls = 8'($urandom_range(0, 255));
            end else begin
                lm = 4'($urandom_range(0, 1));
                ls = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            end
            cyc("rnd", ld, ps, st, tk, lm, ls);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
